// File: rtl/cmos_pkg.sv
// Shared constants for the OV5640 DVP capture front end.
package cmos_pkg;
    localparam int WAIT_FRAME_DEF = 10;
    localparam int PIX_W_DEF      = 12;
    localparam int RGB_W          = 16;
    localparam bit HI_FIRST       = 1'b1;
endpackage

// File: rtl/cmos_capture_data_frame_meter.sv
// Frame geometry meter: pixels per line and lines per frame, saturating counters.
module cmos_frame_meter
    import cmos_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_done,
    input  logic             href_fall,
    input  logic             vs_rise,
    output logic [PIX_W-1:0] h_pixels,
    output logic [PIX_W-1:0] v_lines
);
    logic [PIX_W-1:0] pix_cnt;
    logic [PIX_W-1:0] line_cnt;
    logic [PIX_W-1:0] h_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            h_last   <= '0;
            h_pixels <= '0;
            v_lines  <= '0;
        end else begin
            if (href_fall) begin
                pix_cnt <= '0;
                h_last  <= pix_cnt;
            end else if (pix_done && pix_cnt != '1) begin
                pix_cnt <= pix_cnt + 1'b1;
            end

            if (vs_rise) begin
                line_cnt <= '0;
                v_lines  <= line_cnt;
                h_pixels <= h_last;
            end else if (href_fall && line_cnt != '1) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/cmos_capture_data.sv
// OV5640 8-bit DVP to RGB565 capture: skips settling frames, emits pixel strobes
// and a per-frame load pulse, and measures frame geometry.
module cmos_capture_data
    import cmos_pkg::*;
#(
    parameter int WAIT_FRAME = WAIT_FRAME_DEF,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic             cam_pclk,
    input  logic             rst,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_data,
    output logic             cmos_frame_vsync,
    output logic             cmos_frame_href,
    output logic             cmos_frame_valid,
    output logic [RGB_W-1:0] cmos_frame_data,
    output logic             wr_load,
    output logic             frame_val,
    output logic [PIX_W-1:0] h_pixels,
    output logic [PIX_W-1:0] v_lines,
    output logic             line_err
);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_FRAME);

    logic       vsync_d0, vsync_d1, href_d0, href_d1;
    logic [7:0] data_d0, data_t;
    logic       byte_flag;
    logic [3:0] frame_cnt, frame_cnt_nxt;
    logic       vs_rise, href_fall, pix_done;

    always_comb begin
        vs_rise       = vsync_d0 & ~vsync_d1;
        href_fall     = ~href_d0 & href_d1;
        pix_done      = href_d0 & byte_flag;
        frame_cnt_nxt = frame_cnt;
        if (vs_rise && frame_cnt != WAIT_CNT)
            frame_cnt_nxt = frame_cnt + 4'd1;
    end

    always_ff @(posedge cam_pclk or posedge rst) begin
        if (rst) begin
            vsync_d0 <= 1'b0;
            vsync_d1 <= 1'b0;
            href_d0  <= 1'b0;
            href_d1  <= 1'b0;
            data_d0  <= '0;
        end else begin
            vsync_d0 <= cam_vsync;
            vsync_d1 <= vsync_d0;
            href_d0  <= cam_href;
            href_d1  <= href_d0;
            data_d0  <= cam_data;
        end
    end

    always_ff @(posedge cam_pclk or posedge rst) begin
        if (rst) begin
            frame_cnt        <= '0;
            frame_val        <= 1'b0;
            byte_flag        <= 1'b0;
            data_t           <= '0;
            cmos_frame_valid <= 1'b0;
            cmos_frame_data  <= '0;
            line_err         <= 1'b0;
            wr_load          <= 1'b0;
            cmos_frame_vsync <= 1'b0;
            cmos_frame_href  <= 1'b0;
        end else begin
            frame_cnt <= frame_cnt_nxt;
            // Enable rises on the counting edge; wr_load below still sees the old value.
            frame_val <= (frame_cnt_nxt == WAIT_CNT);

            if (href_d0) begin
                byte_flag <= ~byte_flag;
                data_t    <= data_d0;
            end else begin
                byte_flag <= 1'b0;
            end

            cmos_frame_valid <= pix_done & frame_val;
            if (pix_done)
                cmos_frame_data <= HI_FIRST ? {data_t, data_d0} : {data_d0, data_t};

            // Odd byte left over at line end: the partial pixel is dropped.
            if (href_fall && byte_flag)
                line_err <= 1'b1;

            wr_load          <= vs_rise & frame_val;
            cmos_frame_vsync <= vsync_d1 & frame_val;
            cmos_frame_href  <= href_d1 & frame_val;
        end
    end

    cmos_frame_meter #(.PIX_W(PIX_W)) u_meter (
        .clk       (cam_pclk),
        .rst       (rst),
        .pix_done  (pix_done),
        .href_fall (href_fall),
        .vs_rise   (vs_rise),
        .h_pixels  (h_pixels),
        .v_lines   (v_lines)
    );
endmodule

// File: tb/tb_cmos_capture_data.sv
// Directed bench for cmos_capture_data: frame gating, byte pairing, geometry, reset.
module tb_cmos_capture_data;
    localparam int WF = 2;

    logic        cam_pclk = 1'b0;
    logic        rst = 1'b1;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;

    logic        cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, wr_load, frame_val, line_err;
    logic [15:0] cmos_frame_data;
    logic [11:0] h_pixels, v_lines;

    logic        s_vsync, s_href, s_valid, s_load, s_fval, s_err;
    logic [15:0] s_data;
    logic [3:0]  s_h, s_v;

    cmos_capture_data #(.WAIT_FRAME(WF), .PIX_W(12)) dut (
        .cam_pclk(cam_pclk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .cmos_frame_vsync(cmos_frame_vsync), .cmos_frame_href(cmos_frame_href),
        .cmos_frame_valid(cmos_frame_valid), .cmos_frame_data(cmos_frame_data), .wr_load(wr_load),
        .frame_val(frame_val), .h_pixels(h_pixels), .v_lines(v_lines), .line_err(line_err)
    );

    cmos_capture_data #(.WAIT_FRAME(WF), .PIX_W(4)) dut_s (
        .cam_pclk(cam_pclk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .cmos_frame_vsync(s_vsync), .cmos_frame_href(s_href),
        .cmos_frame_valid(s_valid), .cmos_frame_data(s_data), .wr_load(s_load),
        .frame_val(s_fval), .h_pixels(s_h), .v_lines(s_v), .line_err(s_err)
    );

    always #5 cam_pclk = ~cam_pclk;

    int errors = 0;
    int checks = 0;
    int n_valid = 0;
    int n_load = 0;
    int v0, l0;

    always @(negedge cam_pclk) begin
        if (cmos_frame_valid) n_valid++;
        if (wr_load) n_load++;
    end

    typedef struct {
        int vs, h, d;
        int load, valid, chk, data, vso, ho, err;
    } vec_t;
    vec_t tbl[16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cam_pclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        cam_vsync = v;
        cam_href  = h;
        cam_data  = d;
    endtask

    task automatic send_line(input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            drive(1'b0, 1'b1, 8'(i + 8'h30));
            tick();
        end
        drive(1'b0, 1'b0, 8'h00);
        tick();
        tick();
    endtask

    task automatic vs_pulse();
        drive(1'b1, 1'b0, 8'h00);
        repeat (3) tick();
        drive(1'b0, 1'b0, 8'h00);
        repeat (3) tick();
    endtask

    task automatic send_frame(input int nlines, input int nbytes);
        vs_pulse();
        for (int i = 0; i < nlines; i++) send_line(nbytes);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, " valid"}, int'(cmos_frame_valid), 0);
        check({tag, " data"}, int'(cmos_frame_data), 0);
        check({tag, " vsync_o"}, int'(cmos_frame_vsync), 0);
        check({tag, " href_o"}, int'(cmos_frame_href), 0);
        check({tag, " wr_load"}, int'(wr_load), 0);
        check({tag, " frame_val"}, int'(frame_val), 0);
        check({tag, " h_pixels"}, int'(h_pixels), 0);
        check({tag, " v_lines"}, int'(v_lines), 0);
        check({tag, " line_err"}, int'(line_err), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        //          vs h  d     load valid chk data      vso ho err
        tbl[0]  = '{1, 0, 'h00, 0,   0,    0,  'h0000,   0,  0, 0};
        tbl[1]  = '{1, 0, 'h00, 1,   0,    0,  'h0000,   0,  0, 0};
        tbl[2]  = '{0, 0, 'h00, 0,   0,    0,  'h0000,   1,  0, 0};
        tbl[3]  = '{0, 0, 'h00, 0,   0,    0,  'h0000,   1,  0, 0};
        tbl[4]  = '{0, 1, 'hAB, 0,   0,    0,  'h0000,   0,  0, 0};
        tbl[5]  = '{0, 1, 'hCD, 0,   0,    0,  'h0000,   0,  0, 0};
        tbl[6]  = '{0, 1, 'h12, 0,   1,    1,  'hABCD,   0,  1, 0};
        tbl[7]  = '{0, 1, 'h34, 0,   0,    1,  'hABCD,   0,  1, 0};
        tbl[8]  = '{0, 0, 'h00, 0,   1,    1,  'h1234,   0,  1, 0};
        tbl[9]  = '{0, 0, 'h00, 0,   0,    1,  'h1234,   0,  1, 0};
        tbl[10] = '{0, 1, 'h56, 0,   0,    1,  'h1234,   0,  0, 0};
        tbl[11] = '{0, 1, 'h78, 0,   0,    1,  'h1234,   0,  0, 0};
        tbl[12] = '{0, 1, 'h9A, 0,   1,    1,  'h5678,   0,  1, 0};
        tbl[13] = '{0, 0, 'h00, 0,   0,    1,  'h5678,   0,  1, 0};
        tbl[14] = '{0, 0, 'h00, 0,   0,    1,  'h5678,   0,  1, 1};
        tbl[15] = '{0, 0, 'h00, 0,   0,    1,  'h5678,   0,  0, 1};

        // Reset state
        repeat (3) tick();
        chk_zero("reset");
        check("reset s_h", int'(s_h), 0);
        rst = 1'b0;
        tick();

        // Four 4x8 frames with WAIT_FRAME=2
        for (int f = 1; f <= 4; f++) begin
            v0 = n_valid;
            l0 = n_load;
            send_frame(4, 8);
            check($sformatf("frame%0d valid count", f), n_valid - v0, (f == 1) ? 0 : 16);
            check($sformatf("frame%0d wr_load count", f), n_load - l0, (f >= 3) ? 1 : 0);
            check($sformatf("frame%0d frame_val", f), int'(frame_val), (f == 1) ? 0 : 1);
            if (f == 3) begin
                check("frame3 h_pixels", int'(h_pixels), 4);
                check("frame3 v_lines", int'(v_lines), 4);
            end
        end
        check("after frames line_err", int'(line_err), 0);

        // Cycle-exact vectors: load pulse, AB/CD pairing, latency, odd-byte line
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].vs[0], tbl[i].h[0], tbl[i].d[7:0]);
            tick();
            check($sformatf("vec%0d wr_load", i), int'(wr_load), tbl[i].load);
            check($sformatf("vec%0d valid", i), int'(cmos_frame_valid), tbl[i].valid);
            if (tbl[i].chk != 0)
                check($sformatf("vec%0d data", i), int'(cmos_frame_data), tbl[i].data);
            check($sformatf("vec%0d vsync_o", i), int'(cmos_frame_vsync), tbl[i].vso);
            check($sformatf("vec%0d href_o", i), int'(cmos_frame_href), tbl[i].ho);
            check($sformatf("vec%0d line_err", i), int'(line_err), tbl[i].err);
        end

        // 7-byte line: three pixels, last byte dropped
        v0 = n_valid;
        send_line(7);
        check("odd line valid count", n_valid - v0, 3);
        check("odd line line_err", int'(line_err), 1);

        // 480 lines, last one 640 pixels wide
        vs_pulse();
        for (int i = 0; i < 479; i++) send_line(2);
        send_line(1280);
        vs_pulse();
        check("geom h_pixels", int'(h_pixels), 640);
        check("geom v_lines", int'(v_lines), 480);
        check("geom sat h", int'(s_h), 15);
        check("geom sat v", int'(s_v), 15);
        check("sticky line_err", int'(line_err), 1);

        // 40-byte line on the 4-bit counter instance
        send_line(40);
        vs_pulse();
        check("sat40 h_pixels", int'(h_pixels), 20);
        check("sat40 v_lines", int'(v_lines), 1);
        check("sat40 sat h", int'(s_h), 15);
        check("sat40 sat v", int'(s_v), 1);

        // Asynchronous reset mid-line
        drive(1'b0, 1'b1, 8'hAA);
        repeat (5) tick();
        check("pre-rst frame_val", int'(frame_val), 1);
        #2 rst = 1'b1;
        #1 chk_zero("midrst");
        drive(1'b0, 1'b0, 8'h00);
        tick();
        rst = 1'b0;
        tick();

        for (int f = 1; f <= 3; f++) begin
            v0 = n_valid;
            l0 = n_load;
            send_frame(2, 8);
            check($sformatf("post-rst frame%0d valid count", f), n_valid - v0, (f == 1) ? 0 : 8);
            check($sformatf("post-rst frame%0d wr_load count", f), n_load - l0, (f == 3) ? 1 : 0);
            check($sformatf("post-rst frame%0d frame_val", f), int'(frame_val), (f == 1) ? 0 : 1);
        end
        check("post-rst line_err", int'(line_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
